// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: word width, PC step, reset/NOP defaults,
// next-PC select encoding and the IF/ID record layout.
package fetch_stage_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;
  localparam logic [WORD_W-1:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    PC_SEL_RESET,
    PC_SEL_BRANCH,
    PC_SEL_HOLD,
    PC_SEL_SEQ
  } pc_sel_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
    logic              valid;
  } ifid_t;

  // Branch targets are forced onto a word boundary; the low two bits are dropped.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] value);
    return (value == COUNT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush to a NOP bubble, hold while stalled, otherwise
// capture the freshly fetched instruction and its PC+4.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] inst_in,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] inst_out,
  output logic              valid_out
);

  ifid_t ifid_q;
  ifid_t bubble;

  assign bubble = '{pc: '0, inst: NOP_INST, valid: 1'b0};

  // Flush beats load so a redirect discards whatever was being fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q <= bubble;
    end else if (flush) begin
      ifid_q <= bubble;
    end else if (load) begin
      ifid_q <= '{pc: pc_in, inst: inst_in, valid: 1'b1};
    end
  end

  assign pc_out    = ifid_q.pc;
  assign inst_out  = ifid_q.inst;
  assign valid_out = ifid_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and IF/ID register.
// Optional perf counters (fetch_count, stall_count) exist only with FETCH_PERF_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_inst,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] inst_out,
`ifdef FETCH_PERF_EN
  output logic              valid_out,
  output logic [WORD_W-1:0] fetch_count,
  output logic [WORD_W-1:0] stall_count
`else
  output logic              valid_out
`endif
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] pc_next;
  pc_sel_e           pc_sel;

  // Wraps naturally at 2^32 because the sum is truncated to the word width.
  assign pc_plus4  = pc + PC_INC;
  assign imem_addr = pc;

  // Redirect outranks stall so a branch resolved while frozen is never lost.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (rst) begin
      pc_sel = PC_SEL_RESET;
    end else if (branch_taken) begin
      pc_sel = PC_SEL_BRANCH;
    end else if (freeze) begin
      pc_sel = PC_SEL_HOLD;
    end
  end

  always_comb begin
    pc_next = pc_plus4;
    case (pc_sel)
      PC_SEL_RESET:  pc_next = RESET_PC;
      PC_SEL_BRANCH: pc_next = align_word(branch_addr);
      PC_SEL_HOLD:   pc_next = pc;
      default:       pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .load      (~freeze),
    .pc_in     (pc_plus4),
    .inst_in   (imem_inst),
    .pc_out    (pc_out),
    .inst_out  (inst_out),
    .valid_out (valid_out)
  );

`ifdef FETCH_PERF_EN
  // A sequential select is exactly an edge that loads a real instruction into IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pc_sel == PC_SEL_SEQ) begin
        fetch_count <= sat_inc(fetch_count);
      end
      if (pc_sel == PC_SEL_HOLD) begin
        stall_count <= sat_inc(stall_count);
      end
    end
  end
`endif

endmodule
